// File: rtl/neuron_layer_sequencer_if.sv
// Interface bundling the layer sequencer's control, memory-address, MAC and
// activation signals. master = sequencer side, slave = datapath/control side.
// Perf counter signals exist only when NEURON_SEQ_PERF_EN is defined.
interface neuron_layer_sequencer_if #(
  parameter int NUM_INPUTS  = 16,
  parameter int NUM_NEURONS = 8
);
  localparam int IA_W = $clog2(NUM_INPUTS);
  localparam int WA_W = $clog2(NUM_INPUTS * NUM_NEURONS);
  localparam int NA_W = $clog2(NUM_NEURONS);

  logic                   start;
  logic                   abort;
  logic                   busy;
  logic                   done;
  logic [IA_W-1:0]        in_addr;
  logic [WA_W-1:0]        w_addr;
  logic [NA_W-1:0]        thr_addr;
  logic                   threshold_ready;
  logic                   mac_clear;
  logic                   mac_en;
  logic                   act_bit;
  logic                   out_we;
  logic [NUM_NEURONS-1:0] out_data;
`ifdef NEURON_SEQ_PERF_EN
  logic [31:0]            perf_cycles;
  logic [15:0]            perf_runs;
`endif

  modport master (
    input  start, abort, act_bit,
    output busy, done, in_addr, w_addr, thr_addr, threshold_ready,
           mac_clear, mac_en, out_we, out_data
`ifdef NEURON_SEQ_PERF_EN
    , output perf_cycles, perf_runs
`endif
  );

  modport slave (
    output start, abort, act_bit,
    input  busy, done, in_addr, w_addr, thr_addr, threshold_ready,
           mac_clear, mac_en, out_we, out_data
`ifdef NEURON_SEQ_PERF_EN
    , input perf_cycles, perf_runs
`endif
  );
endinterface

// File: rtl/neuron_layer_sequencer.sv
// Sequences one fully-connected layer through the shared MAC + threshold
// activation datapath and writes the packed activation word once per run.
// Optional macro NEURON_SEQ_PERF_EN adds saturating busy-cycle and run counters.
//
// state      | meaning
// IDLE       | waiting for start
// THR_REQ    | threshold address n presented to threshold memory
// THR_LOAD   | threshold strobed into activation block, MAC cleared
// ACCUM      | input/weight addresses k streamed, MAC enabled one cycle behind
// DRAIN      | final input/weight pair accumulated
// COMPARE    | activation bit captured into out_data[n]
// STORE      | out_data written, done pulsed
module neuron_layer_sequencer #(
  parameter int WIDTH       = 22,
  parameter int NUM_INPUTS  = 16,
  parameter int NUM_NEURONS = 8,
  parameter int IA_W        = $clog2(NUM_INPUTS),
  parameter int WA_W        = $clog2(NUM_INPUTS * NUM_NEURONS),
  parameter int NA_W        = $clog2(NUM_NEURONS)
) (
  input logic                        clk,
  input logic                        rst,
  neuron_layer_sequencer_if.master   bus
);

  // WIDTH only sizes the activation block; it is checked here for sanity.
  if (NUM_INPUTS < 2 || NUM_NEURONS < 2 || WIDTH < 1) begin : g_param_check
    $error("neuron_layer_sequencer: NUM_INPUTS/NUM_NEURONS must be >= 2, WIDTH >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_THR_REQ, S_THR_LOAD, S_ACCUM, S_DRAIN, S_COMPARE, S_STORE
  } state_t;

  localparam logic [IA_W-1:0] K_LAST = IA_W'(NUM_INPUTS - 1);
  localparam logic [NA_W-1:0] N_LAST = NA_W'(NUM_NEURONS - 1);
  localparam logic [WA_W-1:0] W_STEP = WA_W'(NUM_INPUTS);

  state_t                 state_q, state_d;
  logic [NA_W-1:0]        n_q, n_d;
  logic [IA_W-1:0]        k_q, k_d;
  logic [NUM_NEURONS-1:0] out_data_q, out_data_d;
  logic                   abort_clr_q, abort_clr_d;

  logic busy, done, out_we, threshold_ready, mac_clear, mac_en;

  // Next-state, counter updates and Moore outputs.
  always_comb begin
    state_d         = state_q;
    n_d             = n_q;
    k_d             = k_q;
    out_data_d      = out_data_q;
    abort_clr_d     = 1'b0;
    busy            = (state_q != S_IDLE);
    done            = 1'b0;
    out_we          = 1'b0;
    threshold_ready = 1'b0;
    mac_clear       = abort_clr_q;
    mac_en          = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d    = S_THR_REQ;
          n_d        = '0;
          out_data_d = '0;
        end
      end
      S_THR_REQ:  state_d = S_THR_LOAD;
      S_THR_LOAD: begin
        threshold_ready = 1'b1;
        mac_clear       = 1'b1;
        k_d             = '0;
        state_d         = S_ACCUM;
      end
      S_ACCUM: begin
        // Read data lags the address by one cycle, so the first ACCUM cycle
        // has nothing to accumulate yet.
        mac_en = (k_q != '0);
        if (k_q == K_LAST) state_d = S_DRAIN;
        else               k_d     = k_q + 1'b1;
      end
      S_DRAIN: begin
        mac_en  = 1'b1;
        state_d = S_COMPARE;
      end
      S_COMPARE: begin
        out_data_d[n_q] = bus.act_bit;
        if (n_q == N_LAST) begin
          state_d = S_STORE;
        end else begin
          n_d     = n_q + 1'b1;
          state_d = S_THR_REQ;
        end
      end
      S_STORE: begin
        out_we  = 1'b1;
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Abort cancels whatever the case chose; partial out_data is kept.
    if (state_q != S_IDLE && bus.abort) begin
      state_d     = S_IDLE;
      n_d         = n_q;
      k_d         = k_q;
      out_data_d  = out_data_q;
      abort_clr_d = 1'b1;
    end
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      n_q         <= '0;
      k_q         <= '0;
      out_data_q  <= '0;
      abort_clr_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      k_q         <= k_d;
      out_data_q  <= out_data_d;
      abort_clr_q <= abort_clr_d;
    end
  end

  assign bus.busy            = busy;
  assign bus.done            = done;
  assign bus.out_we          = out_we;
  assign bus.threshold_ready = threshold_ready;
  assign bus.mac_clear       = mac_clear;
  assign bus.mac_en          = mac_en;
  assign bus.out_data        = out_data_q;
  assign bus.in_addr         = k_q;
  assign bus.thr_addr        = n_q;
  assign bus.w_addr          = WA_W'(n_q) * W_STEP + WA_W'(k_q);

`ifdef NEURON_SEQ_PERF_EN
  logic [31:0] perf_cycles_q, perf_cycles_d;
  logic [15:0] perf_runs_q, perf_runs_d;

  // Saturating busy-cycle and completed-run counters.
  always_comb begin
    perf_cycles_d = perf_cycles_q;
    perf_runs_d   = perf_runs_q;
    if (busy && perf_cycles_q != '1) perf_cycles_d = perf_cycles_q + 1'b1;
    if (done && perf_runs_q != '1)   perf_runs_d   = perf_runs_q + 1'b1;
  end

  // Perf counters clear only on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_cycles_q <= '0;
      perf_runs_q   <= '0;
    end else begin
      perf_cycles_q <= perf_cycles_d;
      perf_runs_q   <= perf_runs_d;
    end
  end

  assign bus.perf_cycles = perf_cycles_q;
  assign bus.perf_runs   = perf_runs_q;
`endif

endmodule

// File: doc/neuron_layer_sequencer.md
Name: neuron_layer_sequencer

Overview:
- Controller sequencing one fully-connected layer through the shared MAC + threshold activation datapath.
- Per neuron: fetches the threshold, clears the MAC, streams NUM_INPUTS input/weight pairs, samples the 1-bit activation result.
- Packs the result into an output word; writes the word to output memory once per layer run.
- Sits between the layer-level control FSM (start/done) and the MAC, activation and SRAM read ports.

Parameters:
- WIDTH, 22, datapath width of the threshold value (sized to match the activation block).
- NUM_INPUTS, 16, inputs per neuron; must be >= 2.
- NUM_NEURONS, 8, neurons per layer, which is also the output word width; must be >= 2.
- IA_W, $clog2(NUM_INPUTS), input address width.
- WA_W, $clog2(NUM_INPUTS*NUM_NEURONS), weight address width.
- NA_W, $clog2(NUM_NEURONS), neuron/threshold address width.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a layer run; accepted only in IDLE.
- abort  in  1  cancel the current run.
- busy  out  1  high from the cycle after start is accepted until the run returns to IDLE.
- done  out  1  one-cycle pulse, coincident with out_we.
- in_addr  out  IA_W  input activation memory read address.
- w_addr  out  WA_W  weight memory read address.
- thr_addr  out  NA_W  threshold memory read address.
- threshold_ready  out  1  load strobe to the activation block's threshold register.
- mac_clear  out  1  synchronous clear of the MAC accumulator.
- mac_en  out  1  accumulate enable; aligned with read data.
- act_bit  in  1  comparator output from the activation block.
- out_we  out  1  output memory write enable.
- out_data  out  NUM_NEURONS  packed activation bits; bit n holds neuron n.

Behaviour:
- Memory timing: all read ports have 1-cycle latency. The MAC accumulator updates on the edge where mac_en is high. act_bit is combinational from the MAC result.
- Reset:
  - All outputs 0, except out_data, which is also 0.
  - FSM goes to IDLE; neuron counter n and input counter k are cleared.
  - Reset mid-run takes priority over everything; no write is issued.
- FSM states: IDLE, THR_REQ, THR_LOAD, ACCUM, DRAIN, COMPARE, STORE.
- IDLE:
  - start=1 -> THR_REQ, with n=0 and out_data cleared.
  - start while busy is ignored.
- THR_REQ: drive thr_addr=n; go to THR_LOAD.
- THR_LOAD:
  - threshold_ready=1 and mac_clear=1 for exactly this cycle.
  - k=0; go to ACCUM.
- ACCUM:
  - Each cycle drive in_addr=k and w_addr=n*NUM_INPUTS+k.
  - mac_en=1 from the 2nd ACCUM cycle onward (one cycle behind the address).
  - Lasts NUM_INPUTS cycles; after k=NUM_INPUTS-1 go to DRAIN.
- DRAIN: mac_en=1 for the last pair; addresses don't-care (hold); go to COMPARE.
- COMPARE:
  - out_data[n] <= act_bit.
  - If n==NUM_NEURONS-1 go to STORE; else n<=n+1 and go to THR_REQ.
- STORE: out_we=1 and done=1 for one cycle, with out_data stable; go to IDLE.
- mac_en is high for exactly NUM_INPUTS cycles per neuron.
- Per-neuron latency: NUM_INPUTS+4 cycles.
- Run latency: start sampled on edge 0 -> out_we/done in cycle NUM_NEURONS*(NUM_INPUTS+4)+1. Default: cycle 161.
- abort (any non-IDLE state, sampled on the edge):
  - Next state is IDLE; mac_clear=1 in the following cycle; busy drops.
  - No out_we and no done.
  - out_data holds its partial value until the next start.
  - abort and start together in IDLE: start wins.
- Counters never wrap. n and k compare against terminal values exactly; no out-of-range address is ever driven.
- WIDTH is not used in the arithmetic of this block.

Optional Feature:
- Macro: NEURON_SEQ_PERF_EN.
- Defined:
  - Adds output perf_cycles (32 bits) and output perf_runs (16 bits).
  - perf_cycles increments every cycle busy=1 and saturates at all-ones.
  - perf_runs increments on each done and saturates.
  - Both clear on rst only; abort does not clear them.
- Not defined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Default params: model drives act_bit=1 for even n -> out_data=8'h55, out_we/done in cycle 161, busy high cycles 1..161.
- Single neuron check: mac_en high exactly 16 cycles between consecutive mac_clear pulses. w_addr sequence for n=3 is 48..63; thr_addr=3 in the THR_REQ cycle for n=3.
- abort asserted in ACCUM of n=4 -> IDLE next cycle, mac_clear pulse, no out_we/done. New start completes normally with a fresh out_data.
- start held high continuously -> exactly one run per IDLE visit; start pulses during busy are ignored (done count = 1).
- rst asserted in COMPARE of n=7 -> next cycle all outputs 0, state IDLE, no write.
- With NEURON_SEQ_PERF_EN: two full runs -> perf_runs=2, perf_cycles=322. Abort after 10 busy cycles adds 10 to perf_cycles.
